// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and opcode-class decoding for the multi-cycle CPU control FSM.
package cpu_ctrl_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_BR     = 3'd5;

    localparam logic [2:0] OP_LOAD     = 3'd0;
    localparam logic [2:0] OP_STORE    = 3'd1;
    localparam logic [2:0] OP_BR0      = 3'd2;
    localparam logic [2:0] OP_BR1      = 3'd3;
    localparam logic [2:0] OP_ALU_BASE = 3'd4;

    function automatic logic is_mem(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_branch(input logic [2:0] op);
        return (op == OP_BR0) || (op == OP_BR1);
    endfunction

    function automatic logic is_alu(input logic [2:0] op);
        return op >= OP_ALU_BASE;
    endfunction

endpackage

// File: rtl/instret_counter.sv
// Enable counter that silently wraps; reused for retired-instruction and later perf counts.
module instret_counter #(
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic [CNTW-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM sequencing the multi-cycle datapath: fetch, decode, execute, memory, writeback.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 3,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [OPW-1:0]  opcode,
    input  logic            change_pc,
    output logic            im_req,
    input  logic            im_ack,
    output logic            dm_req,
    output logic            dm_we,
    input  logic            dm_ack,
    output logic            ir_load,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            alu_latch,
    output logic            rf_we,
    output logic            wb_sel,
    output logic            busy,
    output logic [2:0]      state,
    output logic [CNTW-1:0] instret
);

    logic [2:0]     state_q;
    logic [2:0]     state_d;
    logic [OPW-1:0] opcode_q;
    logic [2:0]     op_cls;
    logic           im_req_q;
    logic           fetch_done;
    logic           retire;

    assign op_cls     = 3'(opcode_q);
    assign fetch_done = (state_q == S_FETCH) && im_req_q && im_ack;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (fetch_done) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_mem(op_cls))         state_d = S_MEM;
                else if (is_branch(op_cls)) state_d = S_BR;
                else                        state_d = S_WB;
            end
            S_MEM: begin
                if (dm_ack) begin
                    if (op_cls == OP_STORE) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB, S_BR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    // A pending fetch survives run falling; only the ack clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            im_req_q <= 1'b0;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                im_req_q <= im_req_q ? !im_ack : run;
            end else begin
                im_req_q <= 1'b0;
            end
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
            end
        end
    end

    instret_counter #(.CNTW(CNTW)) u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire),
        .count (instret)
    );

    assign im_req    = im_req_q;
    assign ir_load   = fetch_done;
    assign pc_inc    = fetch_done;
    assign alu_latch = (state_q == S_EXEC);
    assign dm_req    = (state_q == S_MEM);
    assign dm_we     = (state_q == S_MEM) && (op_cls == OP_STORE);
    assign rf_we     = (state_q == S_WB);
    assign wb_sel    = (state_q == S_WB) && (op_cls == OP_LOAD);
    // pc_load overrides the increment already applied during FETCH.
    assign pc_load   = (state_q == S_BR) && change_pc;
    assign busy      = (state_q != S_FETCH) || im_req_q;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized trace-model bench for multicycle_ctrl (CNTW shrunk to 4 to reach the wrap).
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, run, change_pc, im_ack, dm_ack;
    logic [2:0] opcode;
    logic       im_req, dm_req, dm_we, ir_load, pc_inc, pc_load;
    logic       alu_latch, rf_we, wb_sel, busy;
    logic [2:0] state;
    logic [3:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.OPW(3), .CNTW(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .change_pc(change_pc),
        .im_req(im_req), .im_ack(im_ack), .dm_req(dm_req), .dm_we(dm_we), .dm_ack(dm_ack),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .alu_latch(alu_latch),
        .rf_we(rf_we), .wb_sel(wb_sel), .busy(busy), .state(state), .instret(instret)
    );

    typedef struct packed {
        logic run, im_ack, dm_ack, change_pc;
        logic [2:0] opcode;
    } stim_t;

    // flags order: im_req dm_req dm_we ir_load pc_inc pc_load alu_latch rf_we wb_sel
    typedef struct packed {
        logic [2:0] state;
        logic [8:0] flags;
        logic       busy;
        logic [3:0] instret;
    } obs_t;

    localparam logic [8:0] F_IMR = 9'b100000000;
    localparam logic [8:0] F_DMR = 9'b010000000;
    localparam logic [8:0] F_DMW = 9'b001000000;
    localparam logic [8:0] F_IRL = 9'b000100000;
    localparam logic [8:0] F_PCI = 9'b000010000;
    localparam logic [8:0] F_PCL = 9'b000001000;
    localparam logic [8:0] F_ALU = 9'b000000100;
    localparam logic [8:0] F_RFW = 9'b000000010;
    localparam logic [8:0] F_WBS = 9'b000000001;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    obs_t  obs_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    m_instret = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] rop();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.state   = state;
        o.flags   = {im_req, dm_req, dm_we, ir_load, pc_inc, pc_load, alu_latch, rf_we, wb_sel};
        o.busy    = busy;
        o.instret = instret;
        return o;
    endfunction

    task automatic add(input logic r, input logic ia, input logic da, input logic cp,
                       input logic [2:0] op, input logic [2:0] st, input logic [8:0] f);
        stim_t s;
        obs_t  e;
        s = '{run: r, im_ack: ia, dm_ack: da, change_pc: cp, opcode: op};
        e.state   = st;
        e.flags   = f;
        e.busy    = (st != 3'd0) || f[8];
        e.instret = 4'(m_instret % 16);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // One instruction as the spec describes it: idle fetch, req waits, ack, decode, exec, class tail.
    task automatic build_instr(input logic [2:0] op, input int iw, input int dw, input logic cp);
        add(1'b1, rb(), 1'b0, rb(), rop(), 3'd0, 9'b0);
        for (int k = 0; k < iw; k++) add(rb(), 1'b0, 1'b0, rb(), rop(), 3'd0, F_IMR);
        add(rb(), 1'b1, 1'b0, rb(), rop(), 3'd0, F_IMR | F_IRL | F_PCI);
        add(rb(), rb(), 1'b0, rb(), op, 3'd1, 9'b0);
        add(rb(), rb(), 1'b0, rb(), rop(), 3'd2, F_ALU);
        if (op <= 3'd1) begin
            for (int k = 0; k <= dw; k++)
                add(rb(), rb(), (k == dw), rb(), rop(), 3'd3, F_DMR | ((op == 3'd1) ? F_DMW : 9'b0));
            if (op == 3'd0) add(rb(), rb(), 1'b0, rb(), rop(), 3'd4, F_RFW | F_WBS);
        end else if (op <= 3'd3) begin
            add(rb(), rb(), 1'b0, cp, rop(), 3'd5, cp ? F_PCL : 9'b0);
        end else begin
            add(rb(), rb(), 1'b0, rb(), rop(), 3'd4, F_RFW);
        end
        m_instret++;
    endtask

    task automatic build_idle(input int n);
        for (int k = 0; k < n; k++) add(1'b0, rb(), 1'b0, rb(), rop(), 3'd0, 9'b0);
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            {run, im_ack, dm_ack, change_pc, opcode} = stim_q[i];
            #1;
            obs_q.push_back(sample());
        end
    endtask

    task automatic clear_q();
        stim_q.delete();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0; run = 1'b1; im_ack = 1'b1; dm_ack = 1'b1; change_pc = 1'b1; opcode = 3'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            o = sample();
            n_cmp++;
            if (o !== '0) begin
                n_bad++;
                $display("FAIL reset_low cycle %0d: got %b want all zero", i, o);
            end
        end
        @(negedge clk);
        run = 1'b0; im_ack = 1'b0; dm_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        o = sample();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL reset_release: got %b want all zero", o);
        end
    endtask

    task automatic test_alu();
        build_instr(3'($urandom_range(4, 7)), 0, 0, rb());
        play(stim_q.size());
        for (int i = 0; i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL alu_trace cycle %0d: got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_load_delayed();
        build_instr(3'd0, 0, 3, 1'b0);
        play(stim_q.size());
        n_cmp++;
        if (obs_q.size() !== 9) begin
            n_bad++;
            $display("FAIL load_length: got %0d want 9", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL load_trace cycle %0d: got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_store();
        build_instr(3'd1, $urandom_range(0, 2), $urandom_range(0, 3), rb());
        play(stim_q.size());
        for (int i = 0; i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL store_trace cycle %0d: got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_branch();
        build_instr(3'd2, 0, 0, 1'b1);
        build_instr(3'd3, 1, 0, 1'b0);
        play(stim_q.size());
        for (int i = 0; i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL branch_trace cycle %0d: got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_run_drop();
        build_instr(rop(), 2, 1, rb());
        build_idle(5);
        play(stim_q.size());
        for (int i = 0; i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL run_drop_trace cycle %0d: got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 25; n++) begin
            build_instr(rop(), $urandom_range(0, 3), $urandom_range(0, 3), rb());
            build_idle($urandom_range(0, 2));
        end
        play(stim_q.size());
        for (int i = 0; i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL random_trace cycle %0d: got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        clear_q();
    endtask

    task automatic test_reset_mid_mem();
        obs_t o;
        build_instr(3'd0, 0, 6, 1'b0);
        play(6);
        for (int i = 0; i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL pre_reset_trace cycle %0d: got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        clear_q();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        o = sample();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_mem: got %b want all zero", o);
        end
        m_instret = 0;
        run = 1'b0; im_ack = 1'b0; dm_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        o = sample();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_release: got %b want all zero", o);
        end
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 16; n++) build_instr(3'($urandom_range(4, 7)), 0, 0, rb());
        build_idle(1);
        play(stim_q.size());
        for (int i = 0; i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL wrap_trace cycle %0d: got %b want %b", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (instret !== 4'h0) begin
            n_bad++;
            $display("FAIL wrap_final: got instret %0d want 0", instret);
        end
        clear_q();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_delayed();
        test_store();
        test_branch();
        test_run_drop();
        test_back_to_back();
        test_reset_mid_mem();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
